// File: rtl/uart_tx_queue_pkg.sv
// Shared encodings for the UART transmit queue: FSM states, slave register map,
// STATUS/CTRL bit positions and the MiniUART register offsets used by the master port.
package uart_tx_queue_pkg;

  typedef enum logic [1:0] {
    TXQ_IDLE  = 2'd0,
    TXQ_POLL  = 2'd1,
    TXQ_WRITE = 2'd2,
    TXQ_HOLD  = 2'd3
  } txq_state_e;

  localparam logic [1:0] OFF_TXQ_DATA   = 2'd0;
  localparam logic [1:0] OFF_TXQ_STATUS = 2'd1;
  localparam logic [1:0] OFF_TXQ_CTRL   = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BUSY  = 3;
  localparam int ST_COUNT = 8;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;
  localparam int         UART_LSR_TS   = 5;

endpackage

// File: rtl/uart_txq_fifo.sv
// Byte FIFO with 2^DEPTH_LOG2 entries; a push while full is accepted only when a
// pop happens in the same cycle.
module uart_txq_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [7:0]            din_i,
  output logic [7:0]            head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int                     DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]    CNT_MAX = DEPTH;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of the MiniUART: CPU pushes bytes through the slave port,
// and a bus-master FSM polls the UART LSR and writes each byte once the transmitter idles.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int SETTLE     = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [3:2]  S_ADD_I,
  input  logic [31:0] S_DAT_I,
  output logic [31:0] S_DAT_O,
  input  logic        S_STB_I,
  input  logic        S_WE_I,
  output logic        S_ACK_O,
  output logic [4:2]  M_ADD_O,
  output logic [31:0] M_DAT_O,
  input  logic [31:0] M_DAT_I,
  output logic        M_STB_O,
  output logic        M_WE_O,
  input  logic        M_ACK_I,
  output logic        IRQ_O
);

  localparam int                   SETTLE_W    = $clog2(SETTLE);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE - 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_ONE  = 1;

  txq_state_e            state_q, state_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic                  ovf_q, ovf_d;
  logic                  en_q, en_d;
  logic                  ie_q, ie_d;

  logic                  wr_stb, push, pop;
  logic [7:0]            head;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, empty;
  logic                  unused_ok;

  assign unused_ok = ^{M_DAT_I[31:6], M_DAT_I[4:0], S_DAT_I[31:8]};

  assign S_ACK_O = S_STB_I;
  assign wr_stb  = S_STB_I & S_WE_I;
  assign push    = wr_stb & (S_ADD_I == OFF_TXQ_DATA);
  assign pop     = (state_q == TXQ_WRITE) & M_ACK_I;

  uart_txq_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (CLK_I),
    .rst_ni  (RST_I),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (S_DAT_I[7:0]),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // A dropped byte is one pushed into a full FIFO that is not draining this cycle.
  always_comb begin
    ovf_d = ovf_q;
    en_d  = en_q;
    ie_d  = ie_q;
    if (push && full && !pop) ovf_d = 1'b1;
    if (wr_stb && S_ADD_I == OFF_TXQ_STATUS && S_DAT_I[ST_OVF]) ovf_d = 1'b0;
    if (wr_stb && S_ADD_I == OFF_TXQ_CTRL) begin
      en_d = S_DAT_I[CTRL_EN];
      ie_d = S_DAT_I[CTRL_IE];
    end
  end

  always_comb begin
    S_DAT_O = '0;
    case (S_ADD_I)
      OFF_TXQ_STATUS: begin
        S_DAT_O[ST_EMPTY]                  = empty;
        S_DAT_O[ST_FULL]                   = full;
        S_DAT_O[ST_OVF]                    = ovf_q;
        S_DAT_O[ST_BUSY]                   = (state_q != TXQ_IDLE);
        S_DAT_O[ST_COUNT +: DEPTH_LOG2+1]  = count;
      end
      OFF_TXQ_CTRL: begin
        S_DAT_O[CTRL_EN] = en_q;
        S_DAT_O[CTRL_IE] = ie_q;
      end
      default: S_DAT_O = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q  <= TXQ_IDLE;
      settle_q <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b1;
      ie_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
    end
  end

  // HOLD lasts SETTLE cycles so the UART's ts flag has dropped before the next poll.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      TXQ_IDLE: if (en_q && !empty) state_d = TXQ_POLL;
      TXQ_POLL: if (M_ACK_I) begin
        if (M_DAT_I[UART_LSR_TS]) begin
          state_d = TXQ_WRITE;
        end else begin
          state_d  = TXQ_HOLD;
          settle_d = SETTLE_LOAD;
        end
      end
      TXQ_WRITE: if (M_ACK_I) begin
        state_d  = TXQ_HOLD;
        settle_d = SETTLE_LOAD;
      end
      TXQ_HOLD: begin
        if (settle_q == '0) state_d = TXQ_IDLE;
        else                settle_d = settle_q - SETTLE_ONE;
      end
      default: state_d = TXQ_IDLE;
    endcase
  end

  always_comb begin
    M_STB_O = 1'b0;
    M_WE_O  = 1'b0;
    M_ADD_O = '0;
    M_DAT_O = '0;
    case (state_q)
      TXQ_POLL: begin
        M_STB_O = 1'b1;
        M_ADD_O = OFF_UART_LSR;
      end
      TXQ_WRITE: begin
        M_STB_O = 1'b1;
        M_WE_O  = 1'b1;
        M_ADD_O = OFF_UART_DATA;
        M_DAT_O = {24'b0, head};
      end
      default: ;
    endcase
  end

  assign IRQ_O = ie_q & empty & (state_q == TXQ_IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: slave register access, master poll/write
// sequencing against a zero-wait UART model, overflow and reset abandonment.
module tb_uart_tx_queue;

  localparam int SETTLE = 4;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [3:2]  S_ADD_I = '0;
  logic [31:0] S_DAT_I = '0;
  logic [31:0] S_DAT_O;
  logic        S_STB_I = 1'b0;
  logic        S_WE_I = 1'b0;
  logic        S_ACK_O;
  logic [4:2]  M_ADD_O;
  logic [31:0] M_DAT_O;
  logic [31:0] M_DAT_I;
  logic        M_STB_O;
  logic        M_WE_O;
  logic        M_ACK_I;
  logic        IRQ_O;

  logic        ts = 1'b1;
  logic        ack_en = 1'b1;
  int          tests = 0;
  int          fails = 0;
  int          polls = 0;
  int          writes = 0;
  logic [31:0] last_wdata = '0;

  always #5 CLK_I = ~CLK_I;

  assign M_ACK_I = ack_en & M_STB_O;
  assign M_DAT_I = {26'b0, ts, 5'b0};

  uart_tx_queue #(.DEPTH_LOG2(4), .SETTLE(SETTLE)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .S_ADD_I(S_ADD_I), .S_DAT_I(S_DAT_I), .S_DAT_O(S_DAT_O),
    .S_STB_I(S_STB_I), .S_WE_I(S_WE_I), .S_ACK_O(S_ACK_O),
    .M_ADD_O(M_ADD_O), .M_DAT_O(M_DAT_O), .M_DAT_I(M_DAT_I),
    .M_STB_O(M_STB_O), .M_WE_O(M_WE_O), .M_ACK_I(M_ACK_I),
    .IRQ_O(IRQ_O)
  );

  // UART-side transaction monitor
  always @(posedge CLK_I) begin
    if (RST_I && M_STB_O && M_ACK_I) begin
      if (M_WE_O) begin
        writes     = writes + 1;
        last_wdata = M_DAT_O;
      end else begin
        polls = polls + 1;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    S_ADD_I = a; S_DAT_I = d; S_STB_I = 1'b1; S_WE_I = 1'b1;
    @(posedge CLK_I); #1;
    S_STB_I = 1'b0; S_WE_I = 1'b0; S_DAT_I = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    S_ADD_I = a; S_STB_I = 1'b1; S_WE_I = 1'b0;
    #1;
    d = S_DAT_O;
    @(posedge CLK_I); #1;
    S_STB_I = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    tests++;
    if ({M_STB_O, M_WE_O, M_ADD_O, M_DAT_O, IRQ_O} !== '0) begin
      fails++; $display("FAIL reset_outputs: got stb=%b we=%b add=%h dat=%h irq=%b required all 0",
                        M_STB_O, M_WE_O, M_ADD_O, M_DAT_O, IRQ_O);
    end
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL reset_status: got %h required %h", d, 32'h1); end
    bus_read(2'd2, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL reset_ctrl: got %h required %h", d, 32'h1); end
    bus_read(2'd0, d);
    tests++;
    if (d !== 32'h0) begin fails++; $display("FAIL read_data_zero: got %h required 0", d); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    int p0, w0, low;
    ts = 1'b1; ack_en = 1'b1;
    p0 = polls; w0 = writes;
    bus_write(2'd0, 32'h41);
    tests++;
    if (M_STB_O !== 1'b0) begin fails++; $display("FAIL idle_after_push: stb got %b required 0", M_STB_O); end
    @(posedge CLK_I); #1;
    tests++;
    if ({M_STB_O, M_WE_O, M_ADD_O} !== {1'b1, 1'b0, 3'd1}) begin
      fails++; $display("FAIL poll_cycle: got stb=%b we=%b add=%h required 1 0 1", M_STB_O, M_WE_O, M_ADD_O);
    end
    @(posedge CLK_I); #1;
    tests++;
    if ({M_STB_O, M_WE_O, M_ADD_O, M_DAT_O} !== {1'b1, 1'b1, 3'd0, 32'h41}) begin
      fails++; $display("FAIL write_cycle: got stb=%b we=%b add=%h dat=%h required 1 1 0 00000041",
                        M_STB_O, M_WE_O, M_ADD_O, M_DAT_O);
    end
    low = 0;
    for (int i = 0; i < SETTLE; i++) begin
      @(posedge CLK_I); #1;
      if (!M_STB_O) low++;
    end
    tests++;
    if (low != SETTLE) begin fails++; $display("FAIL settle_quiet: got %0d low cycles required %0d", low, SETTLE); end
    tests++;
    if (polls - p0 != 1 || writes - w0 != 1 || last_wdata !== 32'h41) begin
      fails++; $display("FAIL single_xfer: got polls=%0d writes=%0d data=%h required 1 1 00000041",
                        polls - p0, writes - w0, last_wdata);
    end
    repeat (2) @(posedge CLK_I);
    #1;
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h1) begin fails++; $display("FAIL status_after_drain: got %h required 00000001", d); end
  endtask

  task automatic test_busy_uart();
    int p0, w0, npolls, gap, cyc;
    logic prev;
    ts = 1'b0; ack_en = 1'b1;
    p0 = polls; w0 = writes;
    bus_write(2'd0, 32'h55);
    npolls = 0; gap = 0; prev = 1'b0; cyc = 0;
    while (npolls < 10 && cyc < 300) begin
      @(posedge CLK_I); #1;
      cyc++;
      if (M_STB_O && !M_WE_O && !prev) begin
        if (npolls > 0) begin
          tests++;
          if (gap != SETTLE + 1) begin
            fails++; $display("FAIL poll_spacing: got gap %0d required %0d", gap, SETTLE + 1);
          end
        end
        npolls++;
        gap = 0;
      end else if (!M_STB_O) begin
        gap++;
      end
      prev = M_STB_O;
    end
    tests++;
    if (npolls < 10) begin fails++; $display("FAIL poll_timeout: got %0d polls required 10", npolls); end
    @(posedge CLK_I); #1;
    tests++;
    if (writes != w0) begin fails++; $display("FAIL write_while_busy: got %0d writes required 0", writes - w0); end
    ts = 1'b1;
    cyc = 0;
    while (writes == w0 && cyc < 50) begin
      @(posedge CLK_I); #1;
      cyc++;
    end
    repeat (SETTLE + 2) @(posedge CLK_I);
    #1;
    tests++;
    if (writes - w0 != 1 || last_wdata !== 32'h55 || polls - p0 != 11) begin
      fails++; $display("FAIL busy_release: got writes=%0d data=%h polls=%0d required 1 00000055 11",
                        writes - w0, last_wdata, polls - p0);
    end
  endtask

  task automatic test_overflow_and_full_pop();
    logic [31:0] d;
    int w0, cyc;
    w0 = writes;
    bus_write(2'd2, 32'h0);
    for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h10 + i);
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h1006) begin fails++; $display("FAIL full_ovf_status: got %h required 00001006", d); end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h1002) begin fails++; $display("FAIL ovf_clear: got %h required 00001002", d); end
    tests++;
    if (writes != w0) begin fails++; $display("FAIL disabled_drain: got %0d writes required 0", writes - w0); end
    ts = 1'b1; ack_en = 1'b1;
    bus_write(2'd2, 32'h1);
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    tests++;
    if ({M_STB_O, M_WE_O} !== 2'b11) begin
      fails++; $display("FAIL full_write_state: got stb=%b we=%b required 1 1", M_STB_O, M_WE_O);
    end
    bus_write(2'd0, 32'hAA);
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h100A || last_wdata !== 32'h10) begin
      fails++; $display("FAIL push_pop_full: got status=%h head=%h required 0000100a 00000010", d, last_wdata);
    end
    cyc = 0;
    while (writes - w0 < 17 && cyc < 600) begin
      @(posedge CLK_I); #1;
      cyc++;
    end
    repeat (SETTLE + 2) @(posedge CLK_I);
    #1;
    bus_read(2'd1, d);
    tests++;
    if (writes - w0 != 17 || last_wdata !== 32'hAA || d !== 32'h1) begin
      fails++; $display("FAIL full_drain: got writes=%0d last=%h status=%h required 17 000000aa 00000001",
                        writes - w0, last_wdata, d);
    end
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, d);
    tests++;
    if (d !== 32'h3 || IRQ_O !== 1'b1) begin
      fails++; $display("FAIL irq_drained: got ctrl=%h irq=%b required 00000003 1", d, IRQ_O);
    end
    bus_write(2'd2, 32'h1);
    tests++;
    if (IRQ_O !== 1'b0) begin fails++; $display("FAIL irq_disable: got %b required 0", IRQ_O); end
  endtask

  task automatic test_reset_in_write();
    logic [31:0] d;
    int w0;
    ts = 1'b1; ack_en = 1'b1;
    w0 = writes;
    bus_write(2'd0, 32'h77);
    @(posedge CLK_I); #1;
    @(posedge CLK_I); #1;
    ack_en = 1'b0;
    @(posedge CLK_I); #1;
    tests++;
    if ({M_STB_O, M_WE_O} !== 2'b11) begin
      fails++; $display("FAIL write_stalled: got stb=%b we=%b required 1 1", M_STB_O, M_WE_O);
    end
    #2 RST_I = 1'b0;
    #1;
    tests++;
    if ({M_STB_O, M_WE_O, M_ADD_O, M_DAT_O} !== '0) begin
      fails++; $display("FAIL reset_abandon: got stb=%b we=%b add=%h dat=%h required all 0",
                        M_STB_O, M_WE_O, M_ADD_O, M_DAT_O);
    end
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    ack_en = 1'b1;
    repeat (20) @(posedge CLK_I);
    #1;
    bus_read(2'd1, d);
    tests++;
    if (d !== 32'h1 || writes != w0) begin
      fails++; $display("FAIL after_reset: got status=%h writes=%0d required 00000001 0", d, writes - w0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_busy_uart();
    test_overflow_and_full_pop();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
